// File: rtl/req_retry_pkg.sv
// req_retry_pkg: shared types and sizing helpers for the request/retry controller.
//   state_e  - controller states (idle, request on link, await response, retry gap)
//   cnt_w    - bits needed to hold 0..max_val (at least one bit)
//   umax     - larger of two unsigned values, for width sizing
package req_retry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return ($clog2(max_val + 1) > 1) ? $clog2(max_val + 1) : 1;
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_down_cnt.sv
// rr_down_cnt: loadable down-counter used for both the response timeout and
// the retry gap. Load has priority over counting; counting stops at zero.
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (count cleared to 0)
//   load_i     load load_val_i this cycle
//   load_val_i value to load
//   en_i       decrement enable
//   zero_o     count is zero
module rr_down_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/req_retry_ctrl.sv
// req_retry_ctrl: accepts one client command, issues it on the request link,
// waits for ack/nack with a timeout, and re-issues after a gap on failure up to
// MAX_RETRY times. Outcome is a one-cycle o_done or o_fail pulse.
// Build option: define REQ_RETRY_EXP_BACKOFF_EN to double the gap on each retry
// (GAP << (k-1) before retry k); otherwise every gap is GAP cycles.
//   i_clk, i_rst            clock, asynchronous active-low reset
//   i_cmd_valid/i_cmd_data  client command in; o_cmd_ready high while idle
//   o_req_valid/o_req_data  request out; i_req_ready link handshake
//   i_ack, i_nack           single-cycle responder outcome (ack wins)
//   o_done, o_fail          registered one-cycle outcome pulses
//   o_retry_cnt             retries used by the current/last command
module req_retry_ctrl
  import req_retry_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned TIMEOUT   = 10,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned GAP       = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_cmd_valid,
  input  logic [DATA_W-1:0]               i_cmd_data,
  output logic                            o_cmd_ready,
  output logic                            o_req_valid,
  output logic [DATA_W-1:0]               o_req_data,
  input  logic                            i_req_ready,
  input  logic                            i_ack,
  input  logic                            i_nack,
  output logic                            o_done,
  output logic                            o_fail,
  output logic [cnt_w(MAX_RETRY)-1:0]     o_retry_cnt
);

  localparam int unsigned RW = cnt_w(MAX_RETRY);
`ifdef REQ_RETRY_EXP_BACKOFF_EN
  localparam int unsigned GAP_MAX = (MAX_RETRY > 0) ? (GAP << (MAX_RETRY - 1)) : GAP;
`else
  localparam int unsigned GAP_MAX = GAP;
`endif
  localparam int unsigned TW = cnt_w(umax(TIMEOUT, GAP_MAX));

  state_e              state_q;
  logic                cmd_ready_q;
  logic                req_valid_q;
  logic [DATA_W-1:0]   data_q;
  logic                done_q;
  logic                fail_q;
  logic [RW-1:0]       retry_q;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_en;
  logic                tmr_zero;
  logic [TW-1:0]       gap_len;
  logic                wait_fail;
  logic                last_try;

`ifdef REQ_RETRY_EXP_BACKOFF_EN
  // retry_q still holds k-1 when retry k is being scheduled
  assign gap_len = TW'(GAP) << retry_q;
`else
  assign gap_len = TW'(GAP);
`endif

  // ack outranks both nack and the timeout expiring in the same cycle
  assign wait_fail = (state_q == ST_WAIT) && !i_ack && (i_nack || tmr_zero);
  assign last_try  = (retry_q == RW'(MAX_RETRY));
  assign tmr_en    = (state_q == ST_WAIT) || (state_q == ST_GAP);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if ((state_q == ST_SEND) && i_req_ready) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(TIMEOUT - 1);
    end else if (wait_fail && !last_try) begin
      tmr_load = 1'b1;
      tmr_val  = gap_len - TW'(1);
    end
  end

  rr_down_cnt #(
    .W(TW)
  ) u_tmr (
    .clk_i      (i_clk),
    .rst_ni     (i_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      req_valid_q <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      retry_q     <= '0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            data_q      <= i_cmd_data;
            retry_q     <= '0;
            cmd_ready_q <= 1'b0;
            req_valid_q <= 1'b1;
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_ack) begin
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (wait_fail) begin
            if (last_try) begin
              fail_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              retry_q <= retry_q + RW'(1);
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            req_valid_q <= 1'b1;
            state_q     <= ST_SEND;
          end
        end
        default: begin
          cmd_ready_q <= 1'b1;
          req_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_req_valid = req_valid_q;
  assign o_req_data  = data_q;
  assign o_done      = done_q;
  assign o_fail      = fail_q;
  assign o_retry_cnt = retry_q;

endmodule

// File: tb/tb_req_retry_ctrl.sv
// Bench for req_retry_ctrl. The reference model tracks the command timeline in
// absolute cycle numbers (accept time, gap end time) and derives the expected
// outputs from the phase it is in.
module tb_req_retry_ctrl;

  localparam int DATA_W    = 8;
  localparam int TIMEOUT   = 10;
  localparam int MAX_RETRY = 3;
  localparam int GAP       = 4;
  localparam int RW        = ($clog2(MAX_RETRY + 1) > 1) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef REQ_RETRY_EXP_BACKOFF_EN
  localparam bit BACKOFF = 1'b1;
`else
  localparam bit BACKOFF = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              req_valid;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;
  logic              ack;
  logic              nack;
  logic              done;
  logic              fail;
  logic [RW-1:0]     retry_cnt;

  req_retry_ctrl #(
    .DATA_W   (DATA_W),
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY),
    .GAP      (GAP)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmd_valid(cmd_valid),
    .i_cmd_data (cmd_data),
    .o_cmd_ready(cmd_ready),
    .o_req_valid(req_valid),
    .o_req_data (req_data),
    .i_req_ready(req_ready),
    .i_ack      (ack),
    .i_nack     (nack),
    .o_done     (done),
    .o_fail     (fail),
    .o_retry_cnt(retry_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc        = 0;
  int m_phase    = 0;  // 0 idle, 1 request on link, 2 awaiting response, 3 gap
  int m_acc_cyc  = 0;
  int m_gap_end  = 0;
  int m_retry    = 0;
  int m_data     = 0;
  int m_done     = 0;
  int m_fail     = 0;

  function automatic int gap_len(input int k);
    return BACKOFF ? GAP * (1 << (k - 1)) : GAP;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = 0; m_retry = 0; m_data = 0; m_done = 0; m_fail = 0;
      end else begin
        m_done = 0;
        m_fail = 0;
        case (m_phase)
          0: if (cmd_valid) begin
               m_data = int'(cmd_data); m_retry = 0; m_phase = 1;
             end
          1: if (req_ready) begin
               m_phase = 2; m_acc_cyc = cyc;
             end
          2: if (ack) begin
               m_done = 1; m_phase = 0;
             end else if (nack || (cyc - m_acc_cyc == TIMEOUT)) begin
               if (m_retry == MAX_RETRY) begin
                 m_fail = 1; m_phase = 0;
               end else begin
                 m_retry++;
                 m_gap_end = cyc + gap_len(m_retry);
                 m_phase = 3;
               end
             end
          default: if (cyc == m_gap_end) m_phase = 1;
        endcase
        cyc++;
      end
    end
  end

  // ---------------- compare + event monitor ----------------
  bit cmp_en = 1'b0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int fail_cnt = 0;
  int done_cyc = 0;
  int fail_cyc = 0;
  int hs_cyc[8];
  int exp_payload = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cmd_ready", int'(cmd_ready), (m_phase == 0) ? 1 : 0);
        chk("req_valid", int'(req_valid), (m_phase == 1) ? 1 : 0);
        chk("req_data", int'(req_data), m_data);
        chk("done", int'(done), m_done);
        chk("fail", int'(fail), m_fail);
        chk("retry_cnt", int'(retry_cnt), m_retry);
        if (rst) begin
          if (req_valid && req_ready) begin
            chk("hs_data", int'(req_data), exp_payload);
            if (hs_cnt < 8) hs_cyc[hs_cnt] = cyc;
            hs_cnt++;
          end
          if (done) begin done_cnt++; done_cyc = cyc; end
          if (fail) begin fail_cnt++; fail_cyc = cyc; end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hs_cnt = 0; done_cnt = 0; fail_cnt = 0;
  endtask

  task automatic issue(input int d);
    cmd_valid = 1'b1;
    cmd_data  = DATA_W'(d);
    exp_payload = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_hs(input int n, input string nm);
    int b = 0;
    while (hs_cnt < n && b < 300) begin step(); b++; end
    if (hs_cnt < n) chk({nm, "_hs_timeout"}, hs_cnt, n);
  endtask

  task automatic wait_pulse(input string nm);
    int b = 0;
    while ((done_cnt + fail_cnt) == 0 && b < 300) begin step(); b++; end
    if ((done_cnt + fail_cnt) == 0) chk({nm, "_pulse_timeout"}, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    req_ready = 1'b0; ack = 1'b0; nack = 1'b0;
    step(); step();
    // reset state
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_req_valid", int'(req_valid), 0);
    chk("rst_req_data", int'(req_data), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    cmp_en = 1'b1;
    rst = 1'b1;
    step();

    // 1: single attempt, ack on 3rd response cycle
    clr(); req_ready = 1'b1;
    issue(8'hA5);
    wait_hs(1, "t1");
    step(); step();
    ack = 1'b1; step(); ack = 1'b0;
    wait_pulse("t1");
    chk("t1_hs", hs_cnt, 1);
    chk("t1_done", done_cnt, 1);
    chk("t1_fail", fail_cnt, 0);
    chk("t1_lat", done_cyc - hs_cyc[0], 4);
    chk("t1_retry", int'(retry_cnt), 0);
    chk("t1_ready", int'(cmd_ready), 1);

    // 2: no response at all, retries exhausted
    clr();
    issue(8'h3C);
    wait_pulse("t2");
    chk("t2_hs", hs_cnt, 4);
    chk("t2_fail", fail_cnt, 1);
    chk("t2_done", done_cnt, 0);
    chk("t2_retry", int'(retry_cnt), 3);
    chk("t2_gap1", hs_cyc[1] - hs_cyc[0], 15);
    chk("t2_gap2", hs_cyc[2] - hs_cyc[1], BACKOFF ? 19 : 15);
    chk("t2_gap3", hs_cyc[3] - hs_cyc[2], BACKOFF ? 27 : 15);
    chk("t2_fail_lat", fail_cyc - hs_cyc[3], 11);

    // 3: nack first attempt, ack second
    clr();
    issue(8'h5A);
    wait_hs(1, "t3a");
    nack = 1'b1; step(); nack = 1'b0;
    wait_hs(2, "t3b");
    ack = 1'b1; step(); ack = 1'b0;
    wait_pulse("t3");
    chk("t3_hs", hs_cnt, 2);
    chk("t3_reissue", hs_cyc[1] - hs_cyc[0], 6);
    chk("t3_done", done_cnt, 1);
    chk("t3_fail", fail_cnt, 0);
    chk("t3_retry", int'(retry_cnt), 1);

    // 4a: ack coinciding with the timeout cycle
    clr();
    issue(8'hC3);
    wait_hs(1, "t4a");
    repeat (9) step();
    ack = 1'b1; step(); ack = 1'b0;
    wait_pulse("t4a");
    repeat (20) step();
    chk("t4a_lat", done_cyc - hs_cyc[0], 11);
    chk("t4a_hs", hs_cnt, 1);
    chk("t4a_done", done_cnt, 1);
    chk("t4a_fail", fail_cnt, 0);
    chk("t4a_retry", int'(retry_cnt), 0);

    // 4b: ack and nack together
    clr();
    issue(8'h81);
    wait_hs(1, "t4b");
    ack = 1'b1; nack = 1'b1; step(); ack = 1'b0; nack = 1'b0;
    wait_pulse("t4b");
    repeat (20) step();
    chk("t4b_hs", hs_cnt, 1);
    chk("t4b_done", done_cnt, 1);
    chk("t4b_fail", fail_cnt, 0);
    chk("t4b_retry", int'(retry_cnt), 0);

    // 5: reset during the second attempt's response wait
    clr();
    issue(8'hE7);
    wait_hs(2, "t5");
    step(); step(); step();
    chk("t5_pre_retry", int'(retry_cnt), 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_ready", int'(cmd_ready), 1);
    chk("t5_async_valid", int'(req_valid), 0);
    chk("t5_async_data", int'(req_data), 0);
    chk("t5_async_retry", int'(retry_cnt), 0);
    chk("t5_async_done", int'(done), 0);
    chk("t5_async_fail", int'(fail), 0);
    step(); step();
    rst = 1'b1;
    step();
    ack = 1'b1; step(); ack = 1'b0;
    repeat (3) step();
    chk("t5_ready", int'(cmd_ready), 1);
    chk("t5_pulses", done_cnt + fail_cnt, 0);
    chk("t5_hs", hs_cnt, 2);
    chk("t5_retry", int'(retry_cnt), 0);

    // 6: link stalls in SEND for 20 cycles, then ack
    clr(); req_ready = 1'b0;
    issue(8'h77);
    repeat (20) step();
    chk("t6_valid", int'(req_valid), 1);
    chk("t6_data", int'(req_data), 8'h77);
    chk("t6_hs_stall", hs_cnt, 0);
    req_ready = 1'b1; step(); req_ready = 1'b0;
    chk("t6_hs", hs_cnt, 1);
    step();
    ack = 1'b1; step(); ack = 1'b0;
    wait_pulse("t6");
    chk("t6_done", done_cnt, 1);
    chk("t6_fail", fail_cnt, 0);
    chk("t6_retry", int'(retry_cnt), 0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
